core_lsu: RTL and testbench

Load/store unit sitting directly downstream of the execute stage in the RV32I core. It accepts one load or store per request, runs a single-outstanding ready/valid transaction on the data-memory bus, and aligns and sign-extends read data. Loads write back to the general registers. While busy it raises a hold to the pipeline controller, so one access completes before the next is accepted.

---
 rtl/core_lsu_pkg.sv | 44 ++++
 rtl/core_lsu_align.sv | 51 +++++
 rtl/core_lsu.sv | 202 ++++++++++++++++++++
 tb/tb_core_lsu.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_lsu_pkg.sv
// Shared opcode/func3 codes, LSU state encoding and access legality helper.
package core_lsu_pkg;

  localparam logic [6:0] INST_TYPE_L = 7'b0000011;
  localparam logic [6:0] INST_TYPE_S = 7'b0100011;

  localparam logic [2:0] INST_FUNC3_LB  = 3'b000;
  localparam logic [2:0] INST_FUNC3_LH  = 3'b001;
  localparam logic [2:0] INST_FUNC3_LW  = 3'b010;
  localparam logic [2:0] INST_FUNC3_LBU = 3'b100;
  localparam logic [2:0] INST_FUNC3_LHU = 3'b101;
  localparam logic [2:0] INST_FUNC3_SB  = 3'b000;
  localparam logic [2:0] INST_FUNC3_SH  = 3'b001;
  localparam logic [2:0] INST_FUNC3_SW  = 3'b010;

  localparam logic [31:0] ZeroWord   = 32'h0000_0000;
  localparam logic        HoldEnable = 1'b1;
  localparam logic        HoldNone   = 1'b0;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUS  = 2'd1,
    LSU_WB   = 2'd2,
    LSU_ERR  = 2'd3
  } lsu_state_e;

  // True when the access must be rejected: unknown func3 or misaligned address.
  function automatic logic access_fault(input logic       is_load,
                                        input logic [2:0] func3,
                                        input logic [1:0] offset);
    logic legal;
    logic misaligned;
    if (is_load) begin
      legal = (func3 inside {INST_FUNC3_LB, INST_FUNC3_LH, INST_FUNC3_LW,
                             INST_FUNC3_LBU, INST_FUNC3_LHU});
    end else begin
      legal = (func3 inside {INST_FUNC3_SB, INST_FUNC3_SH, INST_FUNC3_SW});
    end
    misaligned = ((func3[1:0] == 2'b01) && offset[0]) ||
                 ((func3[1:0] == 2'b10) && (offset != 2'b00));
    return !legal || misaligned;
  endfunction

endpackage

// File: rtl/core_lsu_align.sv
// Byte-lane steering: store strobes/replicated data and load extraction/extension.
module core_lsu_align
  import core_lsu_pkg::*;
(
  input  logic [2:0]  func3_in,
  input  logic [1:0]  offset_in,
  input  logic [31:0] store_data_in,
  input  logic [31:0] rdata_in,
  output logic [3:0]  wstrb_out,
  output logic [31:0] wdata_out,
  output logic [31:0] load_data_out
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection for both directions, purely combinational.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a latch.
    wstrb_out     = 4'b0000;
    wdata_out     = ZeroWord;
    load_data_out = ZeroWord;
    byte_sel      = rdata_in[{offset_in, 3'b000} +: 8];
    half_sel      = rdata_in[{offset_in[1], 4'b0000} +: 16];

    case (func3_in[1:0])
      2'b00: begin
        wstrb_out = 4'b0001 << offset_in;
        wdata_out = {4{store_data_in[7:0]}};
      end
      2'b01: begin
        wstrb_out = 4'b0011 << {offset_in[1], 1'b0};
        wdata_out = {2{store_data_in[15:0]}};
      end
      default: begin
        wstrb_out = 4'b1111;
        wdata_out = store_data_in;
      end
    endcase

    case (func3_in)
      INST_FUNC3_LB:  load_data_out = {{24{byte_sel[7]}}, byte_sel};
      INST_FUNC3_LH:  load_data_out = {{16{half_sel[15]}}, half_sel};
      INST_FUNC3_LW:  load_data_out = rdata_in;
      INST_FUNC3_LBU: load_data_out = {24'h000000, byte_sel};
      INST_FUNC3_LHU: load_data_out = {16'h0000, half_sel};
      default:        load_data_out = ZeroWord;
    endcase
  end

endmodule

// File: rtl/core_lsu.sv
// Load/store unit: one outstanding data-bus access, load write-back, error pulse.
module core_lsu
  import core_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_in,
  input  logic [6:0]  opcode_in,
  input  logic [2:0]  func3_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  input  logic [4:0]  rd_in,
  output logic        mem_req_out,
  output logic        mem_we_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_wdata_out,
  output logic [3:0]  mem_wstrb_out,
  input  logic        mem_ready_in,
  input  logic [31:0] mem_rdata_in,
  output logic        reg_we_out,
  output logic [4:0]  reg_write_addr_out,
  output logic [31:0] reg_write_data_out,
  output logic        hold_flag_out,
  output logic        err_out
);

  localparam logic [TO_W-1:0] CntLast = TO_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e      state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [6:0]      opcode_q, opcode_d;
  logic [2:0]      func3_q, func3_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     sdata_q, sdata_d;
  logic [4:0]      rd_q, rd_d;
  logic            mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0]     mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]      mem_wstrb_q, mem_wstrb_d;
  logic            reg_we_q, reg_we_d, err_q, err_d;
  logic [4:0]      reg_waddr_q, reg_waddr_d;
  logic [31:0]     reg_wdata_q, reg_wdata_d;

  logic            accept, in_is_load, q_is_load;
  logic [2:0]      al_func3;
  logic [1:0]      al_offset;
  logic [31:0]     al_sdata, al_wdata, al_load;
  logic [3:0]      al_wstrb;

  // Accept decode, combinational hold, and align inputs (live fields in IDLE, latched otherwise).
  always_comb begin
    accept        = req_valid_in && ((opcode_in == INST_TYPE_L) || (opcode_in == INST_TYPE_S));
    in_is_load    = (opcode_in == INST_TYPE_L);
    q_is_load     = (opcode_q == INST_TYPE_L);
    hold_flag_out = ((state_q != LSU_IDLE) || accept) ? HoldEnable : HoldNone;
    if (state_q == LSU_IDLE) begin
      al_func3  = func3_in;
      al_offset = addr_in[1:0];
      al_sdata  = store_data_in;
    end else begin
      al_func3  = func3_q;
      al_offset = addr_q[1:0];
      al_sdata  = sdata_q;
    end
  end

  core_lsu_align u_align (
    .func3_in      (al_func3),
    .offset_in     (al_offset),
    .store_data_in (al_sdata),
    .rdata_in      (mem_rdata_in),
    .wstrb_out     (al_wstrb),
    .wdata_out     (al_wdata),
    .load_data_out (al_load)
  );

  // Next state and next registered outputs; bus fields are rebuilt each BUS cycle so they stay stable.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    opcode_d    = opcode_q;
    func3_d     = func3_q;
    addr_d      = addr_q;
    sdata_d     = sdata_q;
    rd_d        = rd_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = ZeroWord;
    mem_wdata_d = ZeroWord;
    mem_wstrb_d = 4'b0000;
    reg_we_d    = 1'b0;
    reg_waddr_d = 5'd0;
    reg_wdata_d = ZeroWord;
    err_d       = 1'b0;

    case (state_q)
      LSU_IDLE: begin
        if (accept) begin
          opcode_d = opcode_in;
          func3_d  = func3_in;
          addr_d   = addr_in;
          sdata_d  = store_data_in;
          rd_d     = rd_in;
          cnt_d    = '0;
          if (access_fault(in_is_load, func3_in, addr_in[1:0])) begin
            state_d = LSU_ERR;
            err_d   = 1'b1;
          end else begin
            state_d    = LSU_BUS;
            mem_req_d  = 1'b1;
            mem_we_d   = !in_is_load;
            mem_addr_d = {addr_in[31:2], 2'b00};
            if (!in_is_load) begin
              mem_wdata_d = al_wdata;
              mem_wstrb_d = al_wstrb;
            end
          end
        end
      end
      LSU_BUS: begin
        if (mem_ready_in) begin
          cnt_d = '0;
          if (q_is_load) begin
            state_d     = LSU_WB;
            reg_we_d    = (rd_q != 5'd0);
            reg_waddr_d = rd_q;
            reg_wdata_d = al_load;
          end else begin
            state_d = LSU_IDLE;
          end
        end else if (cnt_q == CntLast) begin
          state_d = LSU_ERR;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d      = cnt_q + TO_W'(1);
          mem_req_d  = 1'b1;
          mem_we_d   = !q_is_load;
          mem_addr_d = {addr_q[31:2], 2'b00};
          if (!q_is_load) begin
            mem_wdata_d = al_wdata;
            mem_wstrb_d = al_wstrb;
          end
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  // State, latched request fields and registered outputs; reset drops any bus request at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= LSU_IDLE;
      cnt_q       <= '0;
      opcode_q    <= 7'd0;
      func3_q     <= 3'd0;
      addr_q      <= ZeroWord;
      sdata_q     <= ZeroWord;
      rd_q        <= 5'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= ZeroWord;
      mem_wdata_q <= ZeroWord;
      mem_wstrb_q <= 4'b0000;
      reg_we_q    <= 1'b0;
      reg_waddr_q <= 5'd0;
      reg_wdata_q <= ZeroWord;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      opcode_q    <= opcode_d;
      func3_q     <= func3_d;
      addr_q      <= addr_d;
      sdata_q     <= sdata_d;
      rd_q        <= rd_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      reg_we_q    <= reg_we_d;
      reg_waddr_q <= reg_waddr_d;
      reg_wdata_q <= reg_wdata_d;
      err_q       <= err_d;
    end
  end

  assign mem_req_out        = mem_req_q;
  assign mem_we_out         = mem_we_q;
  assign mem_addr_out       = mem_addr_q;
  assign mem_wdata_out      = mem_wdata_q;
  assign mem_wstrb_out      = mem_wstrb_q;
  assign reg_we_out         = reg_we_q;
  assign reg_write_addr_out = reg_waddr_q;
  assign reg_write_data_out = reg_wdata_q;
  assign err_out            = err_q;

endmodule

// File: tb/tb_core_lsu.sv
// Scoreboard bench for core_lsu: directed accesses push expected bus/write-back/error
// events; a negedge monitor pops and compares whenever the DUT presents one.
module tb_core_lsu;
  import core_lsu_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_in;
  logic [6:0]  opcode_in;
  logic [2:0]  func3_in;
  logic [31:0] addr_in, store_data_in;
  logic [4:0]  rd_in;
  logic        mem_req_out, mem_we_out;
  logic [31:0] mem_addr_out, mem_wdata_out;
  logic [3:0]  mem_wstrb_out;
  logic        mem_ready_in;
  logic [31:0] mem_rdata_in;
  logic        reg_we_out;
  logic [4:0]  reg_write_addr_out;
  logic [31:0] reg_write_data_out;
  logic        hold_flag_out, err_out;

  int checks   = 0;
  int failures = 0;

  typedef enum logic [1:0] {EV_BUS, EV_WB, EV_ERR} ev_kind_e;
  typedef struct packed {
    ev_kind_e    kind;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [4:0]  rd;
    logic [31:0] data;
  } ev_t;
  ev_t exp_q[$];

  core_lsu #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
    .clk                (clk),
    .rst                (rst),
    .req_valid_in       (req_valid_in),
    .opcode_in          (opcode_in),
    .func3_in           (func3_in),
    .addr_in            (addr_in),
    .store_data_in      (store_data_in),
    .rd_in              (rd_in),
    .mem_req_out        (mem_req_out),
    .mem_we_out         (mem_we_out),
    .mem_addr_out       (mem_addr_out),
    .mem_wdata_out      (mem_wdata_out),
    .mem_wstrb_out      (mem_wstrb_out),
    .mem_ready_in       (mem_ready_in),
    .mem_rdata_in       (mem_rdata_in),
    .reg_we_out         (reg_we_out),
    .reg_write_addr_out (reg_write_addr_out),
    .reg_write_data_out (reg_write_data_out),
    .hold_flag_out      (hold_flag_out),
    .err_out            (err_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_bus(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [3:0] ws);
    ev_t e;
    e = '0; e.kind = EV_BUS; e.addr = a; e.we = we; e.wdata = wd; e.wstrb = ws;
    exp_q.push_back(e);
  endtask

  task automatic push_wb(input logic [4:0] rd, input logic [31:0] d);
    ev_t e;
    e = '0; e.kind = EV_WB; e.rd = rd; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    ev_t e;
    e = '0; e.kind = EV_ERR;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_e k);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL unexpected_event: got kind %0d expected none", k);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", 32'(k), 32'(e.kind));
    if (k == e.kind) begin
      case (k)
        EV_BUS: begin
          check("mem_addr", mem_addr_out, e.addr);
          check("mem_we", 32'(mem_we_out), 32'(e.we));
          check("mem_wstrb", 32'(mem_wstrb_out), 32'(e.wstrb));
          if (e.we) check("mem_wdata", mem_wdata_out, e.wdata);
        end
        EV_WB: begin
          check("reg_waddr", 32'(reg_write_addr_out), 32'(e.rd));
          check("reg_wdata", reg_write_data_out, e.data);
        end
        default: ;
      endcase
    end
  endtask

  // Monitor: compare every presented event against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      if (mem_req_out && mem_ready_in) observe(EV_BUS);
      if (reg_we_out) observe(EV_WB);
      if (err_out) observe(EV_ERR);
    end
  end

  // Issue one request at posedge+1 and act as memory; returns per-cycle timing.
  task automatic access(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [4:0] rd, input logic [31:0] rdata,
                        input int wait_cycles, output logic hold_acc, output int req_cycles,
                        output int wb_cycle, output int err_cycle, output int idle_cycle);
    int  bus_seen;
    bit  done;
    bus_seen = 0; req_cycles = 0; wb_cycle = -1; err_cycle = -1; idle_cycle = -1; done = 0;
    req_valid_in = 1'b1; opcode_in = opc; func3_in = f3; addr_in = addr;
    store_data_in = sdata; rd_in = rd;
    #1 hold_acc = hold_flag_out;
    @(posedge clk); #1;
    req_valid_in = 1'b0; opcode_in = '0; func3_in = '0; addr_in = '0; store_data_in = '0; rd_in = '0;
    for (int k = 1; k <= 40 && !done; k++) begin
      if (!hold_flag_out) begin
        idle_cycle = k; done = 1;
      end else begin
        if (reg_we_out && wb_cycle < 0) wb_cycle = k;
        if (err_out && err_cycle < 0) err_cycle = k;
        if (mem_req_out) begin
          req_cycles++;
          if (bus_seen == wait_cycles) begin
            mem_ready_in = 1'b1; mem_rdata_in = rdata;
          end
          bus_seen++;
        end
        @(posedge clk); #1;
        mem_ready_in = 1'b0; mem_rdata_in = '0;
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL access_bound: got hold=1 after 40 cycles expected 0");
    end
  endtask

  logic hacc;
  int   nreq, cwb, cerr, cidle;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req_valid_in = 1'b0; opcode_in = '0; func3_in = '0; addr_in = '0;
    store_data_in = '0; rd_in = '0; mem_ready_in = 1'b0; mem_rdata_in = '0;
    #12;
    check("rst_mem_req", 32'(mem_req_out), 0);
    check("rst_hold", 32'(hold_flag_out), 0);
    check("rst_reg_we", 32'(reg_we_out), 0);
    check("rst_err", 32'(err_out), 0);
    check("rst_mem_addr", mem_addr_out, 0);
    check("rst_reg_wdata", reg_write_data_out, 0);
    #10 rst = 1'b1;
    @(posedge clk); #1;

    // LW zero-wait: full latency profile.
    push_bus(32'h100, 1'b0, 32'h0, 4'b0000); push_wb(5'd5, 32'hDEADBEEF);
    access(INST_TYPE_L, INST_FUNC3_LW, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF, 0, hacc, nreq, cwb, cerr, cidle);
    check("lw_hold_T", 32'(hacc), 1);
    check("lw_req_cycles", nreq, 1);
    check("lw_wb_T2", cwb, 2);
    check("lw_idle_T3", cidle, 3);

    // Byte loads at offset 3, signed and unsigned.
    push_bus(32'h100, 1'b0, 32'h0, 4'b0000); push_wb(5'd6, 32'hFFFFFF80);
    access(INST_TYPE_L, INST_FUNC3_LB, 32'h103, 32'h0, 5'd6, 32'h80FF1122, 0, hacc, nreq, cwb, cerr, cidle);
    push_bus(32'h100, 1'b0, 32'h0, 4'b0000); push_wb(5'd6, 32'h00000080);
    access(INST_TYPE_L, INST_FUNC3_LBU, 32'h103, 32'h0, 5'd6, 32'h80FF1122, 0, hacc, nreq, cwb, cerr, cidle);

    // SH upper half.
    push_bus(32'h200, 1'b1, 32'hABCDABCD, 4'b1100);
    access(INST_TYPE_S, INST_FUNC3_SH, 32'h202, 32'h0000ABCD, 5'd0, 32'h0, 0, hacc, nreq, cwb, cerr, cidle);
    check("sh_no_wb", cwb, -1);
    check("sh_idle_T2", cidle, 2);

    // Misaligned LW.
    push_err();
    access(INST_TYPE_L, INST_FUNC3_LW, 32'h101, 32'h0, 5'd3, 32'h0, 0, hacc, nreq, cwb, cerr, cidle);
    check("mis_no_req", nreq, 0);
    check("mis_err_T1", cerr, 1);
    check("mis_idle_T2", cidle, 2);

    // LH to x0: bus access, no write enable.
    push_bus(32'h100, 1'b0, 32'h0, 4'b0000);
    access(INST_TYPE_L, INST_FUNC3_LH, 32'h102, 32'h0, 5'd0, 32'hBEEF1234, 0, hacc, nreq, cwb, cerr, cidle);
    check("lh_x0_no_we", cwb, -1);
    check("lh_x0_idle_T3", cidle, 3);

    // More load extraction patterns.
    push_bus(32'h100, 1'b0, 32'h0, 4'b0000); push_wb(5'd7, 32'hFFFFBEEF);
    access(INST_TYPE_L, INST_FUNC3_LH, 32'h102, 32'h0, 5'd7, 32'hBEEF1234, 0, hacc, nreq, cwb, cerr, cidle);
    push_bus(32'h100, 1'b0, 32'h0, 4'b0000); push_wb(5'd8, 32'h00008234);
    access(INST_TYPE_L, INST_FUNC3_LHU, 32'h100, 32'h0, 5'd8, 32'h12348234, 0, hacc, nreq, cwb, cerr, cidle);
    push_bus(32'h100, 1'b0, 32'h0, 4'b0000); push_wb(5'd9, 32'h0000007F);
    access(INST_TYPE_L, INST_FUNC3_LB, 32'h101, 32'h0, 5'd9, 32'h00007F00, 0, hacc, nreq, cwb, cerr, cidle);

    // Store lanes.
    push_bus(32'h300, 1'b1, 32'hA5A5A5A5, 4'b0010);
    access(INST_TYPE_S, INST_FUNC3_SB, 32'h301, 32'h123456A5, 5'd0, 32'h0, 0, hacc, nreq, cwb, cerr, cidle);
    push_bus(32'h400, 1'b1, 32'h11223344, 4'b1111);
    access(INST_TYPE_S, INST_FUNC3_SW, 32'h400, 32'h11223344, 5'd0, 32'h0, 0, hacc, nreq, cwb, cerr, cidle);

    // Illegal func3 and misaligned store.
    push_err();
    access(INST_TYPE_L, 3'b011, 32'h0, 32'h0, 5'd1, 32'h0, 0, hacc, nreq, cwb, cerr, cidle);
    push_err();
    access(INST_TYPE_L, 3'b110, 32'h0, 32'h0, 5'd1, 32'h0, 0, hacc, nreq, cwb, cerr, cidle);
    push_err();
    access(INST_TYPE_S, 3'b100, 32'h0, 32'h0, 5'd0, 32'h0, 0, hacc, nreq, cwb, cerr, cidle);
    push_err();
    access(INST_TYPE_S, INST_FUNC3_SW, 32'h402, 32'h0, 5'd0, 32'h0, 0, hacc, nreq, cwb, cerr, cidle);
    check("sw_mis_err_T1", cerr, 1);

    // Non-memory opcode is ignored.
    access(7'b0110011, INST_FUNC3_LW, 32'h100, 32'h0, 5'd2, 32'h0, 0, hacc, nreq, cwb, cerr, cidle);
    check("other_op_no_hold", 32'(hacc), 0);
    check("other_op_idle", cidle, 1);

    // Wait states.
    push_bus(32'h600, 1'b0, 32'h0, 4'b0000); push_wb(5'd10, 32'h0BADF00D);
    access(INST_TYPE_L, INST_FUNC3_LW, 32'h600, 32'h0, 5'd10, 32'h0BADF00D, 2, hacc, nreq, cwb, cerr, cidle);
    check("wait_req_cycles", nreq, 3);
    check("wait_wb_T4", cwb, 4);

    // Timeout, then a normal store.
    push_err();
    access(INST_TYPE_L, INST_FUNC3_LW, 32'h500, 32'h0, 5'd11, 32'h0, 1000, hacc, nreq, cwb, cerr, cidle);
    check("to_req_cycles", nreq, TO);
    check("to_err_cycle", cerr, TO + 1);
    check("to_no_wb", cwb, -1);
    check("to_idle", cidle, TO + 2);
    push_bus(32'h504, 1'b1, 32'h55667788, 4'b1111);
    access(INST_TYPE_S, INST_FUNC3_SW, 32'h504, 32'h55667788, 5'd0, 32'h0, 0, hacc, nreq, cwb, cerr, cidle);
    check("after_to_sw_idle", cidle, 2);

    // Ready in the same cycle as the timeout: ready wins.
    push_bus(32'h700, 1'b1, 32'hA1B2C3D4, 4'b1111);
    access(INST_TYPE_S, INST_FUNC3_SW, 32'h700, 32'hA1B2C3D4, 5'd0, 32'h0, TO - 1, hacc, nreq, cwb, cerr, cidle);
    check("edge_req_cycles", nreq, TO);
    check("edge_no_err", cerr, -1);
    check("edge_idle", cidle, TO + 1);

    // Reset during BUS drops the request immediately.
    req_valid_in = 1'b1; opcode_in = INST_TYPE_L; func3_in = INST_FUNC3_LW; addr_in = 32'h900; rd_in = 5'd4;
    @(posedge clk); #1;
    req_valid_in = 1'b0; opcode_in = '0; func3_in = '0; addr_in = '0; rd_in = '0;
    check("rst_bus_req_before", 32'(mem_req_out), 1);
    @(posedge clk); #1;
    #2 rst = 1'b0;
    #1;
    check("rst_bus_req_drop", 32'(mem_req_out), 0);
    check("rst_bus_hold_drop", 32'(hold_flag_out), 0);
    check("rst_bus_err", 32'(err_out), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    push_bus(32'h800, 1'b0, 32'h0, 4'b0000); push_wb(5'd9, 32'hCAFEF00D);
    access(INST_TYPE_L, INST_FUNC3_LW, 32'h800, 32'h0, 5'd9, 32'hCAFEF00D, 0, hacc, nreq, cwb, cerr, cidle);
    check("post_rst_wb_T2", cwb, 2);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
